// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns byte/half/word processor accesses into word
// transactions on a multi-cycle memory, using read-modify-write for sub-word stores.
module dmem_ctrl #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              wr,
  input  logic [1:0]        size,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_lane, w_lane_nxt;
  logic [1:0]          r_size, w_size_nxt;
  logic [15:0]         r_wdata, w_wdata_nxt;
  logic [31:0]         r_rdata, w_rdata_nxt;
  logic                r_err, w_err_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [31:0]         r_mem_wdata, w_mem_wdata_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                w_misal;
  logic                w_timeout;

  // Little-endian lane extraction, zero-padded; size 10 behaves as byte.
  function automatic logic [31:0] lane_extract(input logic [31:0] w,
                                               input logic [1:0]  k,
                                               input logic [1:0]  sz);
    logic [31:0] r;
    r = '0;
    case (sz)
      2'b11: r = w;
      2'b01: r = k[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
      default: begin
        case (k)
          2'd0:    r = {24'b0, w[7:0]};
          2'd1:    r = {24'b0, w[15:8]};
          2'd2:    r = {24'b0, w[23:16]};
          default: r = {24'b0, w[31:24]};
        endcase
      end
    endcase
    return r;
  endfunction

  // Insert store data into the addressed byte/half lane of the old word.
  function automatic logic [31:0] lane_merge(input logic [31:0] w,
                                             input logic [15:0] d,
                                             input logic [1:0]  k,
                                             input logic [1:0]  sz);
    logic [31:0] r;
    r = w;
    if (sz == 2'b01) begin
      if (k[1]) r[31:16] = d;
      else      r[15:0]  = d;
    end else begin
      case (k)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

  assign w_misal   = ((size == 2'b11) && (addr[1:0] != 2'b00)) ||
                     ((size == 2'b01) && addr[0]);
  assign w_timeout = !mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

  assign stall     = req & (r_state != S_DONE);
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_lane      <= '0;
      r_size      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lane      <= w_lane_nxt;
      r_size      <= w_size_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lane_nxt      = r_lane;
    w_size_nxt      = r_size;
    w_wdata_nxt     = r_wdata;
    w_rdata_nxt     = r_rdata;
    w_err_nxt       = 1'b0;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_cnt_nxt       = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_lane_nxt     = addr[1:0];
          w_size_nxt     = size;
          w_wdata_nxt    = wdata[15:0];
          w_mem_addr_nxt = addr[ADDR_W+1:2];
          w_cnt_nxt      = '0;
          if (w_misal) begin
            w_rdata_nxt = '0;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else if (!wr) begin
            w_mem_req_nxt = 1'b1;
            w_mem_we_nxt  = 1'b0;
            w_state_nxt   = S_RD;
          end else if (size == 2'b11) begin
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = 1'b1;
            w_mem_wdata_nxt = wdata;
            w_state_nxt     = S_WR;
          end else begin
            w_mem_req_nxt = 1'b1;
            w_mem_we_nxt  = 1'b0;
            w_state_nxt   = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          w_rdata_nxt   = lane_extract(mem_rdata, r_lane, r_size);
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_DONE;
        end else if (w_timeout) begin
          w_mem_req_nxt = 1'b0;
          w_err_nxt     = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RMW_RD: begin
        // mem_req stays high into the write; only mem_we flips.
        if (mem_ack) begin
          w_mem_wdata_nxt = lane_merge(mem_rdata, r_wdata, r_lane, r_size);
          w_mem_we_nxt    = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_WR;
        end else if (w_timeout) begin
          w_mem_req_nxt = 1'b0;
          w_err_nxt     = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WR: begin
        if (mem_ack || w_timeout) begin
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_err_nxt     = !mem_ack;
          w_state_nxt   = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table plus back-to-back and reset-mid-RMW sequences.
module tb_dmem_ctrl;

  localparam int ADDR_W = 30;
  localparam int NO_ACK = 255;
  localparam int NV     = 15;

  logic              clk;
  logic              rst;
  logic              req;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              wr;
  logic [1:0]        size;
  logic [31:0]       rdata;
  logic              stall;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  dmem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata), .wr(wr),
    .size(size), .rdata(rdata), .stall(stall), .err(err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks after ack_lat waiting cycles, never when ack_lat == NO_ACK.
  logic [31:0] mem [16];
  int          ack_lat = 0;
  int          wait_cnt = 0;
  logic        pl_we = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  always @(negedge clk) begin
    mem_rdata = mem[mem_addr[3:0]];
    mem_ack   = mem_req && (ack_lat != NO_ACK) && (wait_cnt >= ack_lat);
  end

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_val;
    else if (mem_req && mem_ack && mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_we  = 1'b1;
    @(posedge clk); #1;
    pl_we  = 1'b0;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_access(input string tag, input logic i_wr, input logic [1:0] i_size,
                           input logic [31:0] i_addr, input logic [31:0] i_wdata,
                           input int i_lat, input bit keep,
                           output int n_stall, output int n_req, output int n_we,
                           output logic [ADDR_W-1:0] fa, output logic [31:0] rd,
                           output logic er, output logic er_after);
    bit done;
    wr = i_wr; size = i_size; addr = i_addr; wdata = i_wdata; req = 1'b1;
    ack_lat = i_lat;
    n_stall = 0; n_req = 0; n_we = 0; fa = '0; rd = '0; er = 1'b0; er_after = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (n_req == 0) fa = mem_addr;
        n_req++;
        if (mem_we) n_we++;
      end
      if (stall) n_stall++;
      else begin
        done = 1'b1;
        rd   = rdata;
        er   = err;
      end
    end
    chk($sformatf("%s done_seen", tag), 32'(done), 32'd1);
    @(posedge clk); #1;
    if (!keep) begin
      req = 1'b0;
      @(negedge clk);
      er_after = err;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    int          lat;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_stall;
    int          exp_req;
    int          exp_we;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vt [NV];

  int                ns, nr, nw;
  logic [ADDR_W-1:0] fa;
  logic [31:0]       rd;
  logic              er, ea;
  string             t;

  initial begin
    //          wr    size   addr    wdata         init          lat     chk   exp_rd        err  st rq we exp_mem
    vt[0]  = '{1'b0, 2'b11, 32'h10, 32'h0,        32'hDEADBEEF, 0,      1'b1, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 2'b00, 32'h13, 32'h0,        32'h8899AABB, 0,      1'b1, 32'h00000088, 1'b0, 2, 1, 0, 32'h8899AABB};
    vt[2]  = '{1'b0, 2'b01, 32'h12, 32'h0,        32'h8899AABB, 0,      1'b1, 32'h00008899, 1'b0, 2, 1, 0, 32'h8899AABB};
    vt[3]  = '{1'b0, 2'b10, 32'h10, 32'h0,        32'h8899AABB, 0,      1'b1, 32'h000000BB, 1'b0, 2, 1, 0, 32'h8899AABB};
    vt[4]  = '{1'b0, 2'b01, 32'h10, 32'h0,        32'h8899AABB, 0,      1'b1, 32'h0000AABB, 1'b0, 2, 1, 0, 32'h8899AABB};
    vt[5]  = '{1'b1, 2'b00, 32'h21, 32'h000000CC, 32'h11223344, 0,      1'b1, 32'h0000AABB, 1'b0, 3, 2, 1, 32'h1122CC44};
    vt[6]  = '{1'b1, 2'b01, 32'h22, 32'hABCD5566, 32'h11223344, 0,      1'b1, 32'h0000AABB, 1'b0, 3, 2, 1, 32'h55663344};
    vt[7]  = '{1'b1, 2'b11, 32'h24, 32'hCAFEF00D, 32'h00000000, 0,      1'b1, 32'h0000AABB, 1'b0, 2, 1, 1, 32'hCAFEF00D};
    vt[8]  = '{1'b0, 2'b01, 32'h05, 32'h0,        32'hA5A5A5A5, 0,      1'b1, 32'h00000000, 1'b1, 1, 0, 0, 32'hA5A5A5A5};
    vt[9]  = '{1'b1, 2'b11, 32'h06, 32'h12345678, 32'hA5A5A5A5, 0,      1'b1, 32'h00000000, 1'b1, 1, 0, 0, 32'hA5A5A5A5};
    vt[10] = '{1'b0, 2'b11, 32'h0C, 32'h0,        32'h01020304, 2,      1'b1, 32'h01020304, 1'b0, 4, 3, 0, 32'h01020304};
    vt[11] = '{1'b1, 2'b00, 32'h33, 32'h00000077, 32'hAABBCCDD, 1,      1'b1, 32'h01020304, 1'b0, 5, 4, 2, 32'h77BBCCDD};
    vt[12] = '{1'b0, 2'b11, 32'h14, 32'h0,        32'h0BADF00D, NO_ACK, 1'b0, 32'h0,        1'b1, 5, 4, 0, 32'h0BADF00D};
    vt[13] = '{1'b1, 2'b00, 32'h18, 32'h00000099, 32'h55555555, NO_ACK, 1'b0, 32'h0,        1'b1, 5, 4, 0, 32'h55555555};
    vt[14] = '{1'b0, 2'b01, 32'h16, 32'h0,        32'h12345678, 3,      1'b1, 32'h00001234, 1'b0, 5, 4, 0, 32'h12345678};

    rst = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    for (int i = 0; i < 16; i++) preload(4'(i), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rdata",     rdata,             32'h0);
    chk("reset err",       32'(err),          32'h0);
    chk("reset mem_req",   32'(mem_req),      32'h0);
    chk("reset mem_we",    32'(mem_we),       32'h0);
    chk("reset mem_addr",  32'(mem_addr),     32'h0);
    chk("reset mem_wdata", mem_wdata,         32'h0);
    chk("reset stall",     32'(stall),        32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      t = $sformatf("v%0d", i);
      preload(vt[i].addr[5:2], vt[i].init);
      do_access(t, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, vt[i].lat, 1'b0,
                ns, nr, nw, fa, rd, er, ea);
      chk({t, " stall_cycles"}, 32'(ns), 32'(vt[i].exp_stall));
      chk({t, " req_cycles"},   32'(nr), 32'(vt[i].exp_req));
      chk({t, " we_cycles"},    32'(nw), 32'(vt[i].exp_we));
      chk({t, " err_done"},     32'(er), 32'(vt[i].exp_err));
      chk({t, " err_after"},    32'(ea), 32'h0);
      chk({t, " mem_word"},     mem[vt[i].addr[5:2]], vt[i].exp_mem);
      if (vt[i].exp_req > 0) chk({t, " mem_addr"}, 32'(fa), 32'(vt[i].addr[31:2]));
      if (vt[i].chk_rd)      chk({t, " rdata"}, rd, vt[i].exp_rd);
    end

    // Back-to-back: req stays high through DONE into the next access.
    preload(4'd4, 32'h8899AABB);
    do_access("b2b0", 1'b0, 2'b11, 32'h10, 32'h0, 0, 1'b1, ns, nr, nw, fa, rd, er, ea);
    chk("b2b0 stall_cycles", 32'(ns), 32'd2);
    chk("b2b0 rdata",        rd,      32'h8899AABB);
    do_access("b2b1", 1'b0, 2'b00, 32'h12, 32'h0, 0, 1'b0, ns, nr, nw, fa, rd, er, ea);
    chk("b2b1 stall_cycles", 32'(ns), 32'd2);
    chk("b2b1 rdata",        rd,      32'h00000099);
    chk("b2b1 err_done",     32'(er), 32'h0);

    // Reset while the RMW write phase is pending.
    preload(4'd2, 32'h11223344);
    wr = 1'b1; size = 2'b00; addr = 32'h09; wdata = 32'h000000EE; ack_lat = 2; req = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rmw_rst in_wr mem_req", 32'(mem_req), 32'h1);
    chk("rmw_rst in_wr mem_we",  32'(mem_we),  32'h1);
    chk("rmw_rst merged",        mem_wdata,    32'h1122EE44);
    rst = 1'b0; req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rmw_rst mem_req",   32'(mem_req),  32'h0);
    chk("rmw_rst mem_we",    32'(mem_we),   32'h0);
    chk("rmw_rst mem_addr",  32'(mem_addr), 32'h0);
    chk("rmw_rst mem_wdata", mem_wdata,     32'h0);
    chk("rmw_rst rdata",     rdata,         32'h0);
    chk("rmw_rst err",       32'(err),      32'h0);
    chk("rmw_rst stall",     32'(stall),    32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rmw_rst mem_unchanged", mem[2], 32'h11223344);
    do_access("post_rst", 1'b0, 2'b11, 32'h08, 32'h0, 0, 1'b0, ns, nr, nw, fa, rd, er, ea);
    chk("post_rst stall_cycles", 32'(ns), 32'd2);
    chk("post_rst rdata",        rd,      32'h11223344);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory controller that sits directly downstream of the single-cycle datapath's Dmem interface (Daddr, DwData, DmemWr, size). It converts byte/half/word processor accesses into word-wide transactions on a multi-cycle memory. Sub-word stores are done as read-modify-write. Processor-side stall is asserted until each access completes. Load data is returned lane-aligned and zero-padded; sign/zero extension stays in the existing load-size selector.

Parameters:
ADDR_W, 30, word-address width on the memory side (memory address = addr[ADDR_W+1:2])
TIMEOUT, 16, maximum cycles to wait for mem_ack before aborting with err (valid range 2..255)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low
req  in  1  processor access request; held stable with addr/wdata/wr/size while stall=1
addr  in  32  byte address (datapath Daddr)
wdata  in  32  store data (datapath DwData); byte/half data taken from low bits
wr  in  1  1=store, 0=load (datapath DmemWr)
size  in  2  11=word, 01=half, 00=byte (10 treated as byte)
rdata  out  32  load data shifted to bits [7:0]/[15:0]/[31:0], upper bits zero
stall  out  1  processor must hold the current instruction
err  out  1  one-cycle pulse: misaligned access or memory timeout
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable, valid with mem_req
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  full-word write data
mem_rdata  in  32  word read data, valid with mem_ack on a read
mem_ack  in  1  one-cycle completion; ignored when mem_req=0

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, rdata=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0. Reset during any state abandons the transaction. The memory must tolerate a dropped mem_req.
- stall = req & (state != DONE), combinational. It is never 1 when req=0.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. A misaligned req in IDLE issues no memory op, goes to DONE, and pulses err there. rdata is 0.
- States:
  - IDLE: on req, latch addr/wdata/wr/size, then:
    - misaligned -> DONE
    - load -> RD
    - word store -> WR
    - byte/half store -> RMW_RD
  - RD: mem_req=1, mem_we=0. On mem_ack, rdata <= lane-extract(mem_rdata) -> DONE.
  - RMW_RD: same as RD, but on mem_ack latch merged word into mem_wdata -> WR.
  - WR: mem_req=1, mem_we=1. On mem_ack -> DONE.
  - DONE: stall=0 for exactly one cycle, rdata valid -> IDLE.
- Lane-extract (little-endian, k=addr[1:0]):
  - byte: rdata = {24'b0, mem_rdata[8k+7:8k]}
  - half: rdata = {16'b0, mem_rdata[16*addr[1]+15 : 16*addr[1]]}
  - word: rdata = mem_rdata
- Merge: replace byte lane k with wdata[7:0], or half lane addr[1] with wdata[15:0]. Other lanes keep the read value.
- Stores leave rdata unchanged.
- Timeout: the counter clears on entry to RD/RMW_RD/WR and increments each cycle without mem_ack. When it reaches TIMEOUT-1 without ack: drop mem_req, go to DONE, pulse err. No write is issued after an RMW read timeout.
- mem_req deasserts the cycle after mem_ack, and in every non-memory state. The RMW_RD->WR transition keeps mem_req=1 and toggles mem_we to 1.
- Back-to-back: req held high through DONE is treated as the next instruction's request in the following IDLE cycle.
- Minimum latency with ack in the first memory cycle:
  - load or word store: 3 cycles (IDLE, RD/WR, DONE); stall high for 2
  - sub-word store: 4 cycles

Test Plan:
- Word load: addr=0x10, mem_rdata=0xDEADBEEF, ack in first RD cycle -> mem_addr=0x4, stall high 2 cycles, rdata=0xDEADBEEF in DONE.
- Byte load: addr=0x13, size=00, mem_rdata=0x8899AABB -> rdata=0x00000088. Half load at addr=0x12 -> rdata=0x00008899.
- Byte store: addr=0x21, wdata=0x000000CC, old word 0x11223344 -> read then write, mem_wdata=0x1122CC44, mem_we 0->1 without mem_req drop, stall 3 cycles.
- Misaligned: half at addr=0x5 -> no mem_req, err pulse 1 cycle, stall 1 cycle, rdata=0.
- Timeout: TIMEOUT=4, load with no mem_ack -> mem_req high 4 cycles then low, err pulse, DONE, return to IDLE.
- Reset mid-RMW: rst=0 in WR -> next cycle mem_req=0, state IDLE, all outputs at reset values. Memory word unchanged.
